// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NREG   = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    // The source that is not s; used for round-robin pointer and age updates.
    function automatic src_t other_src(input src_t s);
        return (s == SRC_A) ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/wr_hold_buf.sv
// One-entry write holding buffer: captures a request on load, drops it on clear.
module wr_hold_buf
    import rf_pkg::*;
(
    input  logic    CLK,
    input  logic    RESET,
    input  logic    load_i,
    input  logic    clear_i,
    input  wr_req_t req_i,
    output logic    valid_o,
    output wr_req_t req_o
);

    logic    valid_q, valid_d;
    wr_req_t req_q, req_d;

    // Load and clear never coincide: load only happens while empty, clear only while full.
    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        if (load_i) begin
            valid_d = 1'b1;
            req_d   = req_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    // Buffer state; synchronous reset drops any held request.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign valid_o = valid_q;
    assign req_o   = req_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between two buffered writeback sources (A and B),
// using round-robin arbitration with same-address write ordering, and exports a busy mask.
module regfile_write_arbiter
    import rf_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              A_VALID,
    output logic              A_READY,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DATA,
    input  logic              B_VALID,
    output logic              B_READY,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DATA,
    output logic              RF_WRITEENABLE,
    output logic [ADDR_W-1:0] RF_WRITEREG,
    output logic [DATA_W-1:0] RF_WRITEDATA,
    output logic              RF_GRANT_B,
    output logic [NREG-1:0]   PENDING
);

    wr_req_t a_in, b_in, a_req, b_req, gnt_req;
    logic    a_valid, b_valid, a_load, b_load, a_clear, b_clear, any_valid;
    src_t    grant;

    src_t              rr_q, rr_d;
    src_t              age_q, age_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_reg_q, rf_reg_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    src_t              rf_src_q, rf_src_d;

    assign a_in = '{addr: A_ADDR, data: A_DATA};
    assign b_in = '{addr: B_ADDR, data: B_DATA};

    // READY is purely the registered empty state of each buffer.
    assign A_READY = ~a_valid;
    assign B_READY = ~b_valid;
    assign a_load  = A_VALID & ~a_valid;
    assign b_load  = B_VALID & ~b_valid;

    wr_hold_buf u_buf_a (
        .CLK     (CLK),
        .RESET   (RESET),
        .load_i  (a_load),
        .clear_i (a_clear),
        .req_i   (a_in),
        .valid_o (a_valid),
        .req_o   (a_req)
    );

    wr_hold_buf u_buf_b (
        .CLK     (CLK),
        .RESET   (RESET),
        .load_i  (b_load),
        .clear_i (b_clear),
        .req_i   (b_in),
        .valid_o (b_valid),
        .req_o   (b_req)
    );

    // Grant selection: same-address conflicts go to the older entry, otherwise round-robin.
    always_comb begin
        any_valid = a_valid | b_valid;
        grant     = SRC_A;
        if (a_valid && b_valid) begin
            grant = (a_req.addr == b_req.addr) ? age_q : rr_q;
        end else if (b_valid) begin
            grant = SRC_B;
        end
        a_clear = any_valid && (grant == SRC_A);
        b_clear = any_valid && (grant == SRC_B);
        gnt_req = (grant == SRC_B) ? b_req : a_req;
    end

    // Next state for the pointer, age bit and write-port registers.
    always_comb begin
        logic a_next, b_next;
        rr_d      = rr_q;
        age_d     = age_q;
        rf_we_d   = 1'b0;
        rf_reg_d  = rf_reg_q;
        rf_data_d = rf_data_q;
        rf_src_d  = rf_src_q;

        if (any_valid) begin
            rr_d      = other_src(grant);
            rf_we_d   = 1'b1;
            rf_reg_d  = gnt_req.addr;
            rf_data_d = gnt_req.data;
            rf_src_d  = grant;
        end

        // Occupancy after this edge decides who is older.
        a_next = a_load | (a_valid & ~a_clear);
        b_next = b_load | (b_valid & ~b_clear);
        if (a_next && b_next) begin
            if (a_load && b_load) begin
                age_d = SRC_A;
            end else if (a_load) begin
                age_d = SRC_B;
            end else if (b_load) begin
                age_d = SRC_A;
            end
        end else if (b_next) begin
            age_d = SRC_B;
        end else begin
            age_d = SRC_A;
        end
    end

    // Arbiter state and registered write-port outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rr_q      <= SRC_A;
            age_q     <= SRC_A;
            rf_we_q   <= 1'b0;
            rf_reg_q  <= '0;
            rf_data_q <= '0;
            rf_src_q  <= SRC_A;
        end else begin
            rr_q      <= rr_d;
            age_q     <= age_d;
            rf_we_q   <= rf_we_d;
            rf_reg_q  <= rf_reg_d;
            rf_data_q <= rf_data_d;
            rf_src_q  <= rf_src_d;
        end
    end

    // Masking with RESET stops an in-flight write from committing at the reset edge.
    assign RF_WRITEENABLE = rf_we_q & ~RESET;
    assign RF_WRITEREG    = rf_reg_q;
    assign RF_WRITEDATA   = rf_data_q;
    assign RF_GRANT_B     = (rf_src_q == SRC_B);

    // Busy mask: anything buffered or currently on the write port.
    always_comb begin
        PENDING = '0;
        if (a_valid) PENDING[a_req.addr] = 1'b1;
        if (b_valid) PENDING[b_req.addr] = 1'b1;
        if (RF_WRITEENABLE) PENDING[RF_WRITEREG] = 1'b1;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, saturation run and random run
// against a timestamp-based reference model, with a simple register file on the write port.
module tb_regfile_write_arbiter;
    import rf_pkg::*;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              A_VALID = 1'b0, B_VALID = 1'b0;
    logic [ADDR_W-1:0] A_ADDR = '0, B_ADDR = '0;
    logic [DATA_W-1:0] A_DATA = '0, B_DATA = '0;
    logic              A_READY, B_READY, RF_WRITEENABLE, RF_GRANT_B;
    logic [ADDR_W-1:0] RF_WRITEREG;
    logic [DATA_W-1:0] RF_WRITEDATA;
    logic [NREG-1:0]   PENDING;

    regfile_write_arbiter dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .A_VALID        (A_VALID),
        .A_READY        (A_READY),
        .A_ADDR         (A_ADDR),
        .A_DATA         (A_DATA),
        .B_VALID        (B_VALID),
        .B_READY        (B_READY),
        .B_ADDR         (B_ADDR),
        .B_DATA         (B_DATA),
        .RF_WRITEENABLE (RF_WRITEENABLE),
        .RF_WRITEREG    (RF_WRITEREG),
        .RF_WRITEDATA   (RF_WRITEDATA),
        .RF_GRANT_B     (RF_GRANT_B),
        .PENDING        (PENDING)
    );

    always #5 CLK = ~CLK;

    // Simple register file fed by the arbiter's write port.
    logic [DATA_W-1:0] rf_mem [NREG];
    logic [DATA_W-1:0] w4_hist [$];
    always @(posedge CLK) begin
        if (RF_WRITEENABLE) begin
            rf_mem[RF_WRITEREG] <= RF_WRITEDATA;
            if (RF_WRITEREG == 3'd4) w4_hist.push_back(RF_WRITEDATA);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each slot remembers the edge number it was filled at.
    bit                m_va, m_vb, m_ptr_b, m_we, m_gb;
    logic [ADDR_W-1:0] m_aa, m_ba, m_reg;
    logic [DATA_W-1:0] m_ad, m_bd, m_data;
    int                m_sa, m_sb, m_edge = 0;
    int                a_wait = 0, b_wait = 0;

    task automatic model_edge();
        bit na, nb, use_b;
        if (RESET) begin
            m_va = 0; m_vb = 0; m_ptr_b = 0; m_we = 0; m_gb = 0; m_reg = '0; m_data = '0;
        end else begin
            na = A_VALID && !m_va;
            nb = B_VALID && !m_vb;
            if (m_va || m_vb) begin
                if (m_va && m_vb)
                    use_b = (m_aa == m_ba) ? (m_sb < m_sa) : m_ptr_b;
                else
                    use_b = m_vb;
                m_we = 1; m_gb = use_b; m_ptr_b = !use_b;
                if (use_b) begin m_reg = m_ba; m_data = m_bd; m_vb = 0; end
                else       begin m_reg = m_aa; m_data = m_ad; m_va = 0; end
            end else begin
                m_we = 0;
            end
            if (na) begin m_va = 1; m_aa = A_ADDR; m_ad = A_DATA; m_sa = m_edge; end
            if (nb) begin m_vb = 1; m_ba = B_ADDR; m_bd = B_DATA; m_sb = m_edge; end
        end
        m_edge++;
    endtask

    function automatic logic [NREG-1:0] model_pending();
        logic [NREG-1:0] p = '0;
        if (m_va) p[m_aa] = 1'b1;
        if (m_vb) p[m_ba] = 1'b1;
        if (m_we) p[m_reg] = 1'b1;
        return p;
    endfunction

    // One clock edge: advance the model, then compare every output shortly after the edge.
    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
        check("a_ready", A_READY, !m_va);
        check("b_ready", B_READY, !m_vb);
        check("rf_we", RF_WRITEENABLE, m_we);
        if (m_we) begin
            check("rf_reg", RF_WRITEREG, m_reg);
            check("rf_data", RF_WRITEDATA, m_data);
            check("rf_gnt_b", RF_GRANT_B, m_gb);
        end
        check("pending", PENDING, model_pending());
        a_wait = A_READY ? 0 : a_wait + 1;
        b_wait = B_READY ? 0 : b_wait + 1;
        check("a_wait_le2", a_wait <= 2, 1);
        check("b_wait_le2", b_wait <= 2, 1);
    endtask

    task automatic drive(input bit rst, input bit av, input logic [ADDR_W-1:0] aa,
                         input logic [DATA_W-1:0] ad, input bit bv,
                         input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
        RESET = rst; A_VALID = av; A_ADDR = aa; A_DATA = ad;
        B_VALID = bv; B_ADDR = ba; B_DATA = bd;
    endtask

    typedef struct {
        bit                rst;
        bit                av;
        logic [ADDR_W-1:0] aa;
        logic [DATA_W-1:0] ad;
        bit                bv;
        logic [ADDR_W-1:0] ba;
        logic [DATA_W-1:0] bd;
        bit                we;
        logic [ADDR_W-1:0] wr;
        logic [DATA_W-1:0] wd;
        bit                gb;
        bit                ar;
        bit                br;
        logic [NREG-1:0]   pend;
    } vec_t;

    vec_t vt [21];

    initial begin
        for (int i = 0; i < int'(NREG); i++) rf_mem[i] = '0;

        //           rst av aa  ad  bv ba  bd   we wr  wd  gb ar br pend
        vt[0]  = '{1, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 1, 1, 8'h00};
        // single write from A
        vt[1]  = '{0, 1, 2, 95, 0, 0, 0,  0, 0, 0,  0, 0, 1, 8'h04};
        vt[2]  = '{0, 0, 0, 0,  0, 0, 0,  1, 2, 95, 0, 1, 1, 8'h04};
        vt[3]  = '{0, 0, 0, 0,  0, 0, 0,  0, 2, 95, 0, 1, 1, 8'h00};
        // simultaneous, different addresses, pointer fresh from reset
        vt[4]  = '{1, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 1, 1, 8'h00};
        vt[5]  = '{0, 1, 1, 28, 1, 4, 6,  0, 0, 0,  0, 0, 0, 8'h12};
        vt[6]  = '{0, 0, 0, 0,  0, 0, 0,  1, 1, 28, 0, 1, 0, 8'h12};
        vt[7]  = '{0, 0, 0, 0,  0, 0, 0,  1, 4, 6,  1, 1, 1, 8'h10};
        vt[8]  = '{0, 0, 0, 0,  0, 0, 0,  0, 4, 6,  1, 1, 1, 8'h00};
        // same-address ordering: 6, 15, then 50
        vt[9]  = '{0, 1, 4, 6,  1, 4, 15, 0, 4, 6,  1, 0, 0, 8'h10};
        vt[10] = '{0, 0, 0, 0,  0, 0, 0,  1, 4, 6,  0, 1, 0, 8'h10};
        vt[11] = '{0, 1, 4, 50, 0, 0, 0,  1, 4, 15, 1, 0, 1, 8'h10};
        vt[12] = '{0, 0, 0, 0,  0, 0, 0,  1, 4, 50, 0, 1, 1, 8'h10};
        vt[13] = '{0, 0, 0, 0,  0, 0, 0,  0, 4, 50, 0, 1, 1, 8'h00};
        // reset while a write is on the port and B is buffered
        vt[14] = '{0, 1, 3, 11, 1, 5, 22, 0, 4, 50, 0, 0, 0, 8'h28};
        vt[15] = '{0, 0, 0, 0,  0, 0, 0,  1, 5, 22, 1, 0, 1, 8'h28};
        vt[16] = '{0, 1, 6, 33, 1, 7, 44, 1, 3, 11, 0, 1, 0, 8'h88};
        vt[17] = '{1, 1, 2, 99, 1, 1, 77, 0, 0, 0,  0, 1, 1, 8'h00};
        // backpressure: A_VALID held two cycles yields a single write
        vt[18] = '{0, 1, 0, 7,  0, 0, 0,  0, 0, 0,  0, 0, 1, 8'h01};
        vt[19] = '{0, 1, 0, 7,  0, 0, 0,  1, 0, 7,  0, 1, 1, 8'h01};
        vt[20] = '{0, 0, 0, 0,  0, 0, 0,  0, 0, 7,  0, 1, 1, 8'h00};

        for (int i = 0; i < 21; i++) begin
            drive(vt[i].rst, vt[i].av, vt[i].aa, vt[i].ad, vt[i].bv, vt[i].ba, vt[i].bd);
            tick();
            check($sformatf("vec%0d_we", i), RF_WRITEENABLE, vt[i].we);
            check($sformatf("vec%0d_reg", i), RF_WRITEREG, vt[i].wr);
            check($sformatf("vec%0d_data", i), RF_WRITEDATA, vt[i].wd);
            check($sformatf("vec%0d_gb", i), RF_GRANT_B, vt[i].gb);
            check($sformatf("vec%0d_ar", i), A_READY, vt[i].ar);
            check($sformatf("vec%0d_br", i), B_READY, vt[i].br);
            check($sformatf("vec%0d_pend", i), PENDING, vt[i].pend);
            if (i == 3) check("reg2_after_single", rf_mem[2], 95);
            if (i == 8) begin
                check("reg1_after_pair", rf_mem[1], 28);
                check("reg4_after_pair", rf_mem[4], 6);
            end
            if (i == 13) begin
                check("reg4_final", rf_mem[4], 50);
                check("reg4_hist_len", w4_hist.size(), 4);
                if (w4_hist.size() == 4) begin
                    check("reg4_order0", w4_hist[1], 6);
                    check("reg4_order1", w4_hist[2], 15);
                    check("reg4_order2", w4_hist[3], 50);
                end
            end
        end
        check("reg5_committed", rf_mem[5], 22);
        check("reg3_dropped", rf_mem[3], 0);
        check("reg7_dropped", rf_mem[7], 0);
        check("reg6_ignored", rf_mem[6], 0);
        check("reg0_single", rf_mem[0], 7);

        // Saturation: both sources always valid, distinct addresses.
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        for (int k = 1; k <= 20; k++) begin
            drive(0, 1, 3'd1, DATA_W'(k), 1, 3'd6, DATA_W'(100 + k));
            tick();
            if (k >= 2) begin
                check($sformatf("sat%0d_we", k), RF_WRITEENABLE, 1);
                check($sformatf("sat%0d_gb", k), RF_GRANT_B, (k % 2) == 1);
            end
        end

        // Random traffic with narrow address range to force same-address conflicts.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
                  ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom),
                  $urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
